// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-type codes
// (funct3 encoding), FSM state encoding and a type-legality helper.
// No ports; imported by dmem_lane_align and dmem_responder.
package dmem_pkg;

  localparam logic [2:0] TYPE_B  = 3'b000;
  localparam logic [2:0] TYPE_H  = 3'b001;
  localparam logic [2:0] TYPE_W  = 3'b010;
  localparam logic [2:0] TYPE_BU = 3'b100;
  localparam logic [2:0] TYPE_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_t;

  // Stores only exist for B/H/W; the unsigned variants are load-only.
  function automatic logic type_legal(input logic is_store, input logic [2:0] acc_type);
    case (acc_type)
      TYPE_B, TYPE_H, TYPE_W: type_legal = 1'b1;
      TYPE_BU, TYPE_HU:       type_legal = !is_store;
      default:                type_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Purpose: byte-lane alignment for one aligned 32-bit storage word.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: word/byte_off/acc_type/wdata in; load_val (extended), byte_en and
// store_word (wdata moved onto the addressed lanes) out.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  acc_type,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word
);

  logic [31:0] shifted;

  always_comb begin
    shifted    = word >> {byte_off, 3'b000};
    store_word = wdata << {byte_off, 3'b000};
    load_val   = '0;
    byte_en    = '0;
    case (acc_type)
      TYPE_B: begin
        load_val = {{24{shifted[7]}}, shifted[7:0]};
        byte_en  = 4'b0001 << byte_off;
      end
      TYPE_H: begin
        load_val = {{16{shifted[15]}}, shifted[15:0]};
        byte_en  = 4'b0011 << byte_off;
      end
      TYPE_W: begin
        load_val = shifted;
        byte_en  = 4'b1111;
      end
      TYPE_BU: load_val = {24'h0, shifted[7:0]};
      TYPE_HU: load_val = {16'h0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Purpose: target end of the CPU data-memory path; one load/store at a time
// against a little-endian byte store. Latency: LATENCY cycles from accept to
// resp_valid. Backpressure: req_ready low while a request is in flight;
// response held stable until resp_ready.
// Ports: clk/reset; req_* valid/ready request channel; resp_* valid/ready
// response channel carrying rdata and err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int  WORDS  = DEPTH / 4;
  localparam int  WAW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int  CW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  // With LATENCY==1 the access happens on the accept edge itself, so it
  // must use the live request fields instead of the captured copy.
  localparam bit  DIRECT = (LATENCY == 1);

  dmem_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        cap_store;
  logic [2:0]  cap_type;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic [31:0] mem_q [WORDS];

  logic        cur_store;
  logic [2:0]  cur_type;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [WAW-1:0] widx;
  logic        misalign;
  logic        acc_err;
  logic        access_fire;
  logic [31:0] load_val;
  logic [3:0]  byte_en;
  logic [31:0] store_word;

  always_comb begin
    cur_store = DIRECT ? req_store : cap_store;
    cur_type  = DIRECT ? req_type : cap_type;
    cur_addr  = DIRECT ? (req_base + req_offset) : cap_addr;
    cur_wdata = DIRECT ? req_wdata : cap_wdata;
    widx      = cur_addr[WAW+1:2];
    misalign  = ((cur_type == TYPE_H || cur_type == TYPE_HU) && cur_addr[0]) ||
                ((cur_type == TYPE_W) && (cur_addr[1:0] != 2'b00));
    acc_err   = (cur_addr >= 32'(DEPTH)) || !type_legal(cur_store, cur_type) || misalign;
    access_fire = (state_q == WAIT && cnt_q == '0) ||
                  (DIRECT && state_q == IDLE && req_valid);
  end

  dmem_lane_align u_align (
    .word       (mem_q[widx]),
    .byte_off   (cur_addr[1:0]),
    .acc_type   (cur_type),
    .wdata      (cur_wdata),
    .load_val   (load_val),
    .byte_en    (byte_en),
    .store_word (store_word)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (DIRECT) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cap_store  <= 1'b0;
      cap_type   <= '0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req_valid) begin
        cap_store <= req_store;
        cap_type  <= req_type;
        cap_addr  <= req_base + req_offset;
        cap_wdata <= req_wdata;
      end
      if (access_fire) begin
        resp_err   <= acc_err;
        resp_rdata <= (acc_err || cur_store) ? 32'h0 : load_val;
      end
    end
  end

  // Storage survives reset; the reset term only guards the LATENCY==1 path,
  // where a request seen during reset would otherwise reach the array.
  always_ff @(posedge clk) begin
    if (access_fire && !reset && cur_store && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem_q[widx][8*i +: 8] <= store_word[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_type;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int failures = 0;

  logic [31:0] rd;
  logic        er;
  int          cyc;

  dmem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_type   (req_type),
    .req_base   (req_base),
    .req_offset (req_offset),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a request at a falling edge, let it be accepted on the next
  // rising edge, then drop req_valid.
  task automatic start_req(input logic st, input logic [2:0] ty,
                           input logic [31:0] b, input logic [31:0] o, input logic [31:0] w);
    @(negedge clk);
    req_store  = st;
    req_type   = ty;
    req_base   = b;
    req_offset = o;
    req_wdata  = w;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
  endtask

  // Counts rising edges after acceptance until resp_valid is seen (bounded).
  task automatic wait_resp(input string tag, output int n);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_resp_seen"}, {31'h0, resp_valid}, 32'h1);
  endtask

  task automatic xact(input string tag, input logic st, input logic [2:0] ty,
                      input logic [31:0] b, input logic [31:0] o, input logic [31:0] w,
                      output logic [31:0] r, output logic e, output int n);
    start_req(st, ty, b, o, w);
    wait_resp(tag, n);
    r = resp_rdata;
    e = resp_err;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_type   = TYPE_W;
    req_base   = '0;
    req_offset = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", {31'h0, resp_err}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Word store then load, with latency measurement
    xact("st_w14", 1'b1, TYPE_W, 32'h10, 32'h4, 32'hDEADBEEF, rd, er, cyc);
    chk("st_w14_err", {31'h0, er}, 32'h0);
    chk("st_w14_rdata", rd, 32'h0);
    chk("st_w14_lat", 32'(cyc), 32'd2);
    xact("ld_w14", 1'b0, TYPE_W, 32'h14, 32'h0, 32'h0, rd, er, cyc);
    chk("ld_w14", rd, 32'hDEADBEEF);
    chk("ld_w14_err", {31'h0, er}, 32'h0);
    chk("ld_w14_lat", 32'(cyc), 32'd2);

    // Extension variants
    xact("ld_b17", 1'b0, TYPE_B, 32'h17, 32'h0, 32'h0, rd, er, cyc);
    chk("ld_b17", rd, 32'hFFFFFFDE);
    xact("ld_bu17", 1'b0, TYPE_BU, 32'h17, 32'h0, 32'h0, rd, er, cyc);
    chk("ld_bu17", rd, 32'h000000DE);
    xact("ld_h14", 1'b0, TYPE_H, 32'h14, 32'h0, 32'h0, rd, er, cyc);
    chk("ld_h14", rd, 32'hFFFFBEEF);
    xact("ld_hu16", 1'b0, TYPE_HU, 32'h16, 32'h0, 32'h0, rd, er, cyc);
    chk("ld_hu16", rd, 32'h0000DEAD);

    // Byte store touches only its lane
    xact("st_b15", 1'b1, TYPE_B, 32'h15, 32'h0, 32'h12345677, rd, er, cyc);
    chk("st_b15_err", {31'h0, er}, 32'h0);
    xact("ld_w14b", 1'b0, TYPE_W, 32'h14, 32'h0, 32'h0, rd, er, cyc);
    chk("ld_w14_after_sb", rd, 32'hDEAD77EF);

    // Error cases
    xact("ld_w13", 1'b0, TYPE_W, 32'h13, 32'h0, 32'h0, rd, er, cyc);
    chk("ld_w13_err", {31'h0, er}, 32'h1);
    chk("ld_w13_rdata", rd, 32'h0);
    xact("ld_h15", 1'b0, TYPE_H, 32'h15, 32'h0, 32'h0, rd, er, cyc);
    chk("ld_h15_err", {31'h0, er}, 32'h1);
    xact("st_w3fc", 1'b1, TYPE_W, 32'h3FC, 32'h0, 32'h11223344, rd, er, cyc);
    chk("st_w3fc_err", {31'h0, er}, 32'h0);
    xact("st_w400", 1'b1, TYPE_W, 32'h400, 32'h0, 32'h55667788, rd, er, cyc);
    chk("st_w400_err", {31'h0, er}, 32'h1);
    xact("ld_w3fc", 1'b0, TYPE_W, 32'h3FC, 32'h0, 32'h0, rd, er, cyc);
    chk("ld_w3fc", rd, 32'h11223344);
    chk("ld_w3fc_err", {31'h0, er}, 32'h0);
    xact("st_hu", 1'b1, TYPE_HU, 32'h14, 32'h0, 32'h0, rd, er, cyc);
    chk("st_hu_err", {31'h0, er}, 32'h1);
    xact("ld_t3", 1'b0, 3'b011, 32'h14, 32'h0, 32'h0, rd, er, cyc);
    chk("ld_type011_err", {31'h0, er}, 32'h1);
    xact("ld_w14c", 1'b0, TYPE_W, 32'h14, 32'h0, 32'h0, rd, er, cyc);
    chk("ld_w14_after_errs", rd, 32'hDEAD77EF);

    // Negative offset wraps modulo 2^32
    xact("st_neg", 1'b1, TYPE_W, 32'h20, 32'hFFFFFFF0, 32'hCAFEF00D, rd, er, cyc);
    chk("st_neg_err", {31'h0, er}, 32'h0);
    xact("ld_w10", 1'b0, TYPE_W, 32'h10, 32'h0, 32'h0, rd, er, cyc);
    chk("ld_w10", rd, 32'hCAFEF00D);

    // Response backpressure; a request pulse meanwhile must be ignored
    resp_ready = 1'b0;
    start_req(1'b0, TYPE_W, 32'h14, 32'h0, 32'h0);
    wait_resp("bp", cyc);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        req_store = 1'b1;
        req_type  = TYPE_W;
        req_base  = 32'h14;
        req_offset = 32'h0;
        req_wdata = 32'h0;
        req_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("bp_resp_valid", {31'h0, resp_valid}, 32'h1);
      chk("bp_rdata", resp_rdata, 32'hDEAD77EF);
      chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_released", {31'h0, resp_valid}, 32'h0);
    xact("ld_w14d", 1'b0, TYPE_W, 32'h14, 32'h0, 32'h0, rd, er, cyc);
    chk("ld_w14_after_bp", rd, 32'hDEAD77EF);

    // Reset during WAIT of a store drops the write
    xact("st_w30", 1'b1, TYPE_W, 32'h30, 32'h0, 32'h01020304, rd, er, cyc);
    start_req(1'b1, TYPE_W, 32'h30, 32'h0, 32'hFFFFFFFF);
    reset = 1'b1;
    #1;
    chk("rw_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rw_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rw_rdata", resp_rdata, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    xact("ld_w30", 1'b0, TYPE_W, 32'h30, 32'h0, 32'h0, rd, er, cyc);
    chk("ld_w30_old", rd, 32'h01020304);

    // Reset during RESP clears the response immediately
    resp_ready = 1'b0;
    start_req(1'b0, TYPE_W, 32'h30, 32'h0, 32'h0);
    wait_resp("rr", cyc);
    chk("rr_rdata_pre", resp_rdata, 32'h01020304);
    #2;
    reset = 1'b1;
    #1;
    chk("rr_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rr_rdata", resp_rdata, 32'h0);
    chk("rr_req_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rr_idle", {31'h0, resp_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
